// File: rtl/barrett_pkg.sv
// Shared types and helpers for the Barrett modular multiplier and its mu divider.
package barrett_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int K_DEFAULT = 32;

  // Widths that follow from the modulus width K.
  function automatic int mu_width(input int k);
    return k + 1;
  endfunction

  function automatic int r_width(input int k);
    return k + 2;
  endfunction

  // Legal moduli sit strictly between 2^(k-1) and 2^k.
  function automatic logic q_is_legal(input logic [63:0] q, input int k);
    logic [63:0] msb;
    msb = 64'd1 << (k - 1);
    return ((q & msb) != 64'd0) && (q != msb);
  endfunction

endpackage

// File: rtl/barrett_mu_div.sv
// Restoring divider producing mu = floor(2^(2K)/q), one quotient bit per cycle over 2K+1 cycles.
// done is high during the final iteration; mu is valid in that same cycle.
module barrett_mu_div
  import barrett_pkg::*;
#(
  parameter int K = K_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [K-1:0]           q,
  output logic                   busy,
  output logic                   done,
  output logic [mu_width(K)-1:0] mu
);

  localparam int MUW   = mu_width(K);
  localparam int CNT_W = $clog2(2 * K + 1);

  logic [CNT_W-1:0] count;
  logic [K-1:0]     rem;
  logic [MUW-1:0]   quo;
  logic [K:0]       rem_sh;
  logic [K:0]       diff;
  logic             fits;
  logic [K-1:0]     rem_nx;

  // The dividend 2^(2K) has a single 1 at its MSB, fed in on the first iteration.
  always_comb begin
    rem_sh = {rem, (count == CNT_W'(2 * K))};
    fits   = rem_sh >= {1'b0, q};
    diff   = rem_sh - {1'b0, q};
    rem_nx = fits ? K'(diff) : K'(rem_sh);
    mu     = MUW'({quo, fits});
    done   = busy && (count == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy  <= 1'b0;
      count <= '0;
      rem   <= '0;
      quo   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= CNT_W'(2 * K);
      rem   <= '0;
      quo   <= '0;
    end else if (busy) begin
      rem <= rem_nx;
      quo <= mu;
      if (count == '0) busy <= 1'b0;
      else count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/barrett_modmul_pipe.sv
// Pipelined (a*b) mod q with run-time modulus; mu is computed on chip after each load.
//   state | meaning
//   IDLE  | no usable modulus loaded, waiting for cfg
//   DIV   | computing mu for the freshly latched q
//   RUN   | q and mu valid, accepting operand pairs
module barrett_modmul_pipe
  import barrett_pkg::*;
#(
  parameter int K         = K_DEFAULT,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_valid,
  input  logic [K-1:0]         cfg_q,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  output logic                 mod_ok,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K-1:0]         in_a,
  input  logic [K-1:0]         in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [K-1:0]         out_y,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int X_W = 2 * K;
  localparam int T_W = 3 * K + 1;
  localparam int MUW = mu_width(K);
  localparam int RW  = r_width(K);

  state_t         state;
  logic [K-1:0]   q_reg;
  logic [MUW-1:0] mu_reg;

  logic           stall, pipe_busy, cfg_take, q_legal, div_start, in_take;
  logic           div_busy, div_done;
  logic [MUW-1:0] div_mu;

  logic                 v1, v2, v3;
  logic [X_W-1:0]       x1, x2, prod_ab;
  logic [MUW-1:0]       qh2, qhat;
  logic [RW-1:0]        r3, r_s3, q_ext, r_a, r_b;
  logic [TAG_WIDTH-1:0] tag1, tag2, tag3;

  always_comb begin
    stall     = out_valid && !out_ready;
    pipe_busy = v1 || v2 || v3 || out_valid;
    cfg_ready = (state != DIV) && !div_busy && !pipe_busy;
    cfg_take  = cfg_valid && cfg_ready;
    q_legal   = q_is_legal(64'(cfg_q), K);
    div_start = cfg_take && q_legal;
    // A pending cfg takes priority over operands in the same cycle.
    in_ready  = (state == RUN) && !stall && !cfg_take;
    in_take   = in_valid && in_ready;
  end

  always_comb begin
    prod_ab = X_W'(in_a) * X_W'(in_b);
    qhat    = MUW'((T_W'(x1) * T_W'(mu_reg)) >> (2 * K));
    // True remainder is below 3q < 2^(K+2), so modular K+2-bit arithmetic is exact.
    r_s3    = RW'(x2) - RW'(qh2) * RW'(q_reg);
    q_ext   = RW'(q_reg);
    r_a     = (r3 >= q_ext) ? r3 - q_ext : r3;
    r_b     = (r_a >= q_ext) ? r_a - q_ext : r_a;
  end

  barrett_mu_div #(.K(K)) u_mu_div (
    .clock (clock),
    .reset (reset),
    .start (div_start),
    .q     (q_reg),
    .busy  (div_busy),
    .done  (div_done),
    .mu    (div_mu)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      q_reg   <= '0;
      mu_reg  <= '0;
      mod_ok  <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (cfg_take) begin
            mod_ok <= 1'b0;
            if (q_legal) begin
              q_reg <= cfg_q;
              state <= DIV;
            end else begin
              cfg_err <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        DIV: begin
          if (div_done) begin
            mu_reg <= div_mu;
            state  <= RUN;
            mod_ok <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          mod_ok <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      x1        <= '0;
      x2        <= '0;
      qh2       <= '0;
      r3        <= '0;
      tag1      <= '0;
      tag2      <= '0;
      tag3      <= '0;
      out_y     <= '0;
      out_tag   <= '0;
    end else if (!stall) begin
      v1        <= in_take;
      x1        <= prod_ab;
      tag1      <= in_tag;
      v2        <= v1;
      x2        <= x1;
      qh2       <= qhat;
      tag2      <= tag1;
      v3        <= v2;
      r3        <= r_s3;
      tag3      <= tag2;
      out_valid <= v3;
      out_y     <= K'(r_b);
      out_tag   <= tag3;
    end
  end

endmodule
